// File: rtl/write_ram_addr_gen.sv
// Write-side address generator for a UART-fed frame buffer.
// Received bytes are stored at consecutive RAM addresses starting at 0.
// A frame closes after IDLE_CYCLES clocks without a received byte. The
// closing cycle publishes the frame length and pulses frameDone.
module write_ram_addr_gen #(
    parameter int IDLE_CYCLES = 50000,
    parameter int MAX_LEN     = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxValid,
    input  logic [7:0] rxData,
    output logic       ramWrEn,
    output logic [7:0] ramWrAddr,
    output logic [7:0] ramWrData,
    output logic       busy,
    output logic [7:0] dataLength,
    output logic       frameDone,
    output logic       overflow
);

    localparam int DATA_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [19:0]       IDLE_LAST = 20'(IDLE_CYCLES - 1);
    localparam logic [DATA_W-1:0] MAX_CNT   = DATA_W'(MAX_LEN);

    logic [1:0]        state;
    logic [DATA_W-1:0] count;
    logic [19:0]       idleCnt;

    logic startFrame;
    logic acceptByte;
    logic dropByte;
    logic closeFrame;

    // The idle counter must never wrap back to a small value, so it sticks at all-ones.
    function automatic logic [19:0] satInc20(input logic [19:0] v);
        return (v == 20'hFFFFF) ? v : v + 20'd1;
    endfunction

    // A byte seen in DONE is treated like one seen in IDLE: it opens a new frame.
    assign startFrame = rxValid && (state != RECV);
    assign acceptByte = rxValid && (state == RECV) && (count < MAX_CNT);
    assign dropByte   = rxValid && (state == RECV) && (count >= MAX_CNT);
    assign closeFrame = !rxValid && (state == RECV) && (idleCnt == IDLE_LAST);

    assign busy      = (state != IDLE);
    assign frameDone = (state == DONE);

    // Frame sequencing: state, byte count, idle timer, overflow flag and published length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            idleCnt    <= '0;
            overflow   <= 1'b0;
            dataLength <= '0;
        end else begin
            if (startFrame) begin
                state    <= RECV;
                count    <= DATA_W'(1);
                idleCnt  <= '0;
                overflow <= 1'b0;
            end else if (acceptByte) begin
                count   <= count + DATA_W'(1);
                idleCnt <= '0;
            end else if (dropByte) begin
                overflow <= 1'b1;
                idleCnt  <= '0;
            end else if (closeFrame) begin
                state      <= DONE;
                dataLength <= count;
            end else if (state == RECV) begin
                idleCnt <= satInc20(idleCnt);
            end else begin
                // DONE without a new byte returns to IDLE; IDLE simply waits.
                state   <= IDLE;
                idleCnt <= '0;
            end
        end
    end

    // RAM write port: registered one cycle behind rxValid; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramWrEn   <= 1'b0;
            ramWrAddr <= '0;
            ramWrData <= '0;
        end else begin
            ramWrEn <= startFrame || acceptByte;
            if (startFrame) begin
                ramWrAddr <= '0;
                ramWrData <= rxData;
            end else if (acceptByte) begin
                ramWrAddr <= count;
                ramWrData <= rxData;
            end
        end
    end

endmodule

// File: tb/tb_write_ram_addr_gen.sv
// Self-checking bench for write_ram_addr_gen. Two instances share the
// stimulus: one with MAX_LEN=255 and one with MAX_LEN=4 for overflow.
module tb_write_ram_addr_gen;

    localparam int IC = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxValid = 1'b0;
    logic [7:0] rxData = 8'h00;

    logic       wrEnA, busyA, fdA, ovfA;
    logic [7:0] addrA, dataA, lenA;
    logic       wrEnB, busyB, fdB, ovfB;
    logic [7:0] addrB, dataB, lenB;

    int nVec = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    write_ram_addr_gen #(.IDLE_CYCLES(IC), .MAX_LEN(255)) dutA (
        .clk(clk), .rst_n(rst_n), .rxValid(rxValid), .rxData(rxData),
        .ramWrEn(wrEnA), .ramWrAddr(addrA), .ramWrData(dataA), .busy(busyA),
        .dataLength(lenA), .frameDone(fdA), .overflow(ovfA)
    );

    write_ram_addr_gen #(.IDLE_CYCLES(IC), .MAX_LEN(4)) dutB (
        .clk(clk), .rst_n(rst_n), .rxValid(rxValid), .rxData(rxData),
        .ramWrEn(wrEnB), .ramWrAddr(addrB), .ramWrData(dataB), .busy(busyB),
        .dataLength(lenB), .frameDone(fdB), .overflow(ovfB)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- frame-level behavioural model ----------------
    // Each model tracks whether a frame is open, how many bytes it holds,
    // and the cycle number of its last received byte. A frame closes when
    // IC cycles pass with no byte; the closing cycle is the frameDone cycle.
    int         cyc = 0;
    int         maxLen [2] = '{255, 4};
    bit         mIn [2], mDone [2], mOvf [2], mWr [2];
    int         mLen [2], mLast [2];
    logic [7:0] mDataLen [2], mAddr [2], mData [2];

    // logs of observed DUT behaviour, used by directed literal checks
    logic [7:0] qAddrA[$], qDataA[$], qAddrB[$], qDataB[$];
    int fdCntA = 0, fdCntB = 0, fdCycA = 0, lastWrCycA = 0;

    task automatic modelStep(input int d);
        mWr[d] = 1'b0;
        if (!rst_n) begin
            mIn[d] = 0; mDone[d] = 0; mOvf[d] = 0; mLen[d] = 0; mLast[d] = 0;
            mDataLen[d] = 8'h00; mAddr[d] = 8'h00; mData[d] = 8'h00;
        end else if ((mDone[d] || !mIn[d]) && rxValid) begin
            mDone[d] = 0; mIn[d] = 1; mLen[d] = 1; mOvf[d] = 0; mLast[d] = cyc;
            mWr[d] = 1; mAddr[d] = 8'h00; mData[d] = rxData;
        end else if (mDone[d]) begin
            mDone[d] = 0; mIn[d] = 0;
        end else if (mIn[d] && rxValid) begin
            mLast[d] = cyc;
            if (mLen[d] < maxLen[d]) begin
                mWr[d] = 1; mAddr[d] = 8'(mLen[d]); mData[d] = rxData; mLen[d]++;
            end else begin
                mOvf[d] = 1;
            end
        end else if (mIn[d] && (cyc - mLast[d] == IC)) begin
            mDone[d] = 1; mDataLen[d] = 8'(mLen[d]);
        end
    endtask

    task automatic compareOne(input string p, input int d, input logic wrEn,
                              input logic [7:0] addr, input logic [7:0] data,
                              input logic busy, input logic [7:0] len,
                              input logic fd, input logic ovf);
        check({p, ".ramWrEn"},    32'(wrEn), 32'(mWr[d]));
        check({p, ".ramWrAddr"},  32'(addr), 32'(mAddr[d]));
        check({p, ".ramWrData"},  32'(data), 32'(mData[d]));
        check({p, ".busy"},       32'(busy), 32'(mIn[d]));
        check({p, ".dataLength"}, 32'(len),  32'(mDataLen[d]));
        check({p, ".frameDone"},  32'(fd),   32'(mDone[d]));
        check({p, ".overflow"},   32'(ovf),  32'(mOvf[d]));
    endtask

    // Advance both models on each rising edge, then compare just after it.
    always @(posedge clk) begin
        cyc++;
        modelStep(0);
        modelStep(1);
        #1;
        compareOne("A", 0, wrEnA, addrA, dataA, busyA, lenA, fdA, ovfA);
        compareOne("B", 1, wrEnB, addrB, dataB, busyB, lenB, fdB, ovfB);
        if (wrEnA) begin qAddrA.push_back(addrA); qDataA.push_back(dataA); lastWrCycA = cyc; end
        if (wrEnB) begin qAddrB.push_back(addrB); qDataB.push_back(dataB); end
        if (fdA) begin fdCntA++; fdCycA = cyc; end
        if (fdB) fdCntB++;
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [7:0] qa(input int i);
        return (qAddrA.size() > i) ? qAddrA[i] : 8'hxx;
    endfunction
    function automatic logic [7:0] qd(input int i);
        return (qDataA.size() > i) ? qDataA[i] : 8'hxx;
    endfunction
    function automatic logic [7:0] qab(input int i);
        return (qAddrB.size() > i) ? qAddrB[i] : 8'hxx;
    endfunction
    function automatic logic [7:0] qdb(input int i);
        return (qDataB.size() > i) ? qDataB[i] : 8'hxx;
    endfunction

    task automatic sendByte(input logic [7:0] b);
        rxValid = 1'b1;
        rxData  = b;
        @(negedge clk);
        rxValid = 1'b0;
        rxData  = 8'hEE;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearLogs();
        qAddrA.delete(); qDataA.delete(); qAddrB.delete(); qDataB.delete();
        fdCntA = 0; fdCntB = 0;
    endtask

    initial begin
        logic [7:0] basicData [3];
        int bad;
        basicData = '{8'h11, 8'h22, 8'h33};

        // reset
        idle(3);
        check("rst.dataLength", 32'(lenA), 32'h0);
        check("rst.busy", 32'(busyA), 32'h0);
        check("rst.ramWrAddr", 32'(addrA), 32'h0);
        rst_n = 1'b1;

        // basic frame: three bytes ten cycles apart
        clearLogs();
        sendByte(8'h11); idle(9);
        sendByte(8'h22); idle(9);
        sendByte(8'h33); idle(30);
        check("basic.nWrites", 32'(qAddrA.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("basic.addr", 32'(qa(i)), 32'(i));
            check("basic.data", 32'(qd(i)), 32'(basicData[i]));
        end
        check("basic.frameDones", 32'(fdCntA), 32'd1);
        check("basic.dataLength", 32'(lenA), 32'd3);
        check("basic.overflow", 32'(ovfA), 32'd0);
        check("basic.doneDelay", 32'(fdCycA - lastWrCycA), 32'(IC));
        check("basic.busyAfter", 32'(busyA), 32'd0);

        // overflow: six bytes into a 4-byte frame
        clearLogs();
        for (int i = 0; i < 6; i++) begin
            sendByte(8'hA0 + 8'(i)); idle(1);
        end
        check("ovf.flagDuring", 32'(ovfB), 32'd1);
        idle(30);
        check("ovf.nWrites", 32'(qAddrB.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("ovf.addr", 32'(qab(i)), 32'(i));
            check("ovf.data", 32'(qdb(i)), 32'(8'hA0 + 8'(i)));
        end
        check("ovf.dataLength", 32'(lenB), 32'd4);
        check("ovf.flagHeld", 32'(ovfB), 32'd1);
        check("ovf.wideLength", 32'(lenA), 32'd6);
        clearLogs();
        sendByte(8'h55);
        check("ovf.clearedOnStart", 32'(ovfB), 32'd0);
        check("ovf.newAddr", 32'(qab(0)), 32'd0);
        idle(30);
        check("ovf.newLength", 32'(lenB), 32'd1);

        // idle boundary: second byte at idle count IC-2 stays in the frame
        clearLogs();
        sendByte(8'h01); idle(IC - 2);
        sendByte(8'h02); idle(30);
        check("edge.nWrites", 32'(qAddrA.size()), 32'd2);
        check("edge.addr1", 32'(qa(1)), 32'd1);
        check("edge.frameDones", 32'(fdCntA), 32'd1);
        check("edge.dataLength", 32'(lenA), 32'd2);

        // gap of IC+5 cycles: two single-byte frames
        clearLogs();
        sendByte(8'h03); idle(IC + 4);
        check("gap.firstClosed", 32'(fdCntA), 32'd1);
        check("gap.firstLength", 32'(lenA), 32'd1);
        sendByte(8'h04); idle(30);
        check("gap.frameDones", 32'(fdCntA), 32'd2);
        check("gap.secondLength", 32'(lenA), 32'd1);
        check("gap.addr1", 32'(qa(1)), 32'd0);

        // byte arriving in the DONE cycle opens a new frame at address 0
        clearLogs();
        sendByte(8'h05); idle(IC);
        sendByte(8'h06);
        check("sim.frameDones", 32'(fdCntA), 32'd1);
        check("sim.busy", 32'(busyA), 32'd1);
        check("sim.dataLength", 32'(lenA), 32'd1);
        check("sim.addr", 32'(qa(1)), 32'd0);
        check("sim.data", 32'(qd(1)), 32'h06);
        idle(30);
        check("sim.secondDone", 32'(fdCntA), 32'd2);

        // reset in the middle of a frame
        clearLogs();
        sendByte(8'h07); idle(1);
        sendByte(8'h08); idle(1);
        rst_n = 1'b0;
        #1;
        check("rstMid.ramWrEn", 32'(wrEnA), 32'd0);
        check("rstMid.ramWrAddr", 32'(addrA), 32'd0);
        check("rstMid.ramWrData", 32'(dataA), 32'd0);
        check("rstMid.busy", 32'(busyA), 32'd0);
        check("rstMid.dataLength", 32'(lenA), 32'd0);
        check("rstMid.frameDone", 32'(fdA), 32'd0);
        check("rstMid.overflowB", 32'(ovfB), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(30);
        check("rstMid.noDone", 32'(fdCntA), 32'd0);
        check("rstMid.lengthKept", 32'(lenA), 32'd0);
        clearLogs();
        sendByte(8'h09);
        check("rstMid.restartAddr", 32'(qa(0)), 32'd0);
        check("rstMid.restartData", 32'(qd(0)), 32'h09);
        idle(30);
        check("rstMid.newLength", 32'(lenA), 32'd1);

        // back-to-back: 255 bytes on consecutive cycles
        clearLogs();
        rxValid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            rxData = 8'(i);
            @(negedge clk);
        end
        rxValid = 1'b0;
        idle(30);
        check("b2b.nWrites", 32'(qAddrA.size()), 32'd255);
        bad = 0;
        for (int i = 0; i < 255; i++)
            if (qa(i) !== 8'(i) || qd(i) !== 8'(i)) bad++;
        check("b2b.sequence", 32'(bad), 32'd0);
        check("b2b.dataLength", 32'(lenA), 32'd255);
        check("b2b.overflow", 32'(ovfA), 32'd0);
        check("b2b.frameDones", 32'(fdCntA), 32'd1);
        check("b2b.lengthB", 32'(lenB), 32'd4);
        check("b2b.overflowB", 32'(ovfB), 32'd1);
        check("b2b.nWritesB", 32'(qAddrB.size()), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/write_ram_addr_gen.md
WRITE_RAM_ADDR_GEN -- requirements
Module: write_ram_addr_gen

Interface
REQ-001 Parameter IDLE_CYCLES, default 50000, meaning: count of clk cycles with no received byte that closes a frame (legal range 2..2^20-1).
REQ-002 Parameter MAX_LEN, default 255, meaning: maximum bytes stored per frame (legal range 1..255).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rxValid  input  1  single-cycle pulse from the UART receiver: rxData holds a new byte.
REQ-006 rxData  input  8  received byte, valid only while rxValid=1.
REQ-007 ramWrEn  output  1  RAM write strobe, one cycle per stored byte.
REQ-008 ramWrAddr  output  8  RAM write address.
REQ-009 ramWrData  output  8  RAM write data.
REQ-010 busy  output  1  high while a frame is being received.
REQ-011 dataLength  output  8  byte count of the last completed frame; feeds the read-side address generator.
REQ-012 frameDone  output  1  single-cycle pulse when a frame closes.
REQ-013 overflow  output  1  high when the last or current frame had bytes dropped beyond MAX_LEN.

Function
REQ-014 FSM states: IDLE, RECV, DONE; encoding is free.
REQ-015 IDLE: on rxValid=1, go to RECV, write the byte at address 0, set the byte count to 1, clear overflow, and clear the idle counter.
REQ-016 RECV: on rxValid=1 with count<MAX_LEN, write the byte at address=count, increment count, and clear the idle counter.
REQ-017 RECV: on rxValid=1 with count=MAX_LEN, drop the byte (no ramWrEn), set overflow=1, and clear the idle counter.
REQ-018 RECV: with no rxValid, increment the idle counter; at IDLE_CYCLES-1 with no rxValid that cycle, go to DONE.
REQ-019 DONE lasts exactly one cycle: load dataLength=count, pulse frameDone=1, then go to IDLE.
REQ-020 A byte whose rxValid falls in the DONE cycle starts a new frame exactly as in IDLE, at address 0; the closing frame's dataLength and frameDone are unaffected.
REQ-021 Write latency is 1 cycle: ramWrEn/ramWrAddr/ramWrData are registered and valid in the cycle after rxValid.
REQ-022 ramWrEn is 0 in every cycle without an accepted byte.
REQ-023 ramWrAddr and ramWrData hold their last values when ramWrEn=0.
REQ-024 busy=1 in RECV and DONE, and 0 in IDLE.
REQ-025 dataLength changes only on entry to DONE and holds between frames.
REQ-026 overflow is set per REQ-017 and holds until the next frame start (REQ-015) or reset.
REQ-027 The idle counter is 20 bits and saturates, never wraps.
REQ-028 Byte count arithmetic is 8-bit unsigned and never exceeds MAX_LEN.
REQ-029 No wrap-around of ramWrAddr within a frame.

Reset
REQ-030 rst_n=0 asynchronously forces all of the following at once:
- state=IDLE
- ramWrEn=0, ramWrAddr=0, ramWrData=0
- busy=0
- dataLength=0
- frameDone=0, overflow=0
- count=0, idle counter=0
REQ-031 Reset mid-frame discards the partial frame: no frameDone, and dataLength keeps its reset value 0.
REQ-032 The first rxValid sampled after rst_n rises is processed normally.

Verification
REQ-033 Basic frame: 3 bytes 0x11,0x22,0x33 spaced 10 cycles apart, then silence -> writes (0,0x11),(1,0x22),(2,0x33); frameDone pulses IDLE_CYCLES cycles after the last byte; dataLength=3; overflow=0.
REQ-034 Overflow: MAX_LEN=4, send 6 bytes -> exactly 4 writes at addresses 0..3; dataLength=4; overflow=1 until the next frame's first byte.
REQ-035 Idle boundary: second byte arrives at idle count IDLE_CYCLES-2 -> same frame (address 1); with a gap of IDLE_CYCLES+5 instead -> two frames, each with dataLength=1.
REQ-036 Simultaneous close/start: rxValid during the DONE cycle -> frameDone for the old frame; the new byte is written at address 0; busy stays 1.
REQ-037 Reset mid-frame: rst_n low after 2 of 5 bytes -> outputs reach reset values immediately; no frameDone; the next frame starts at address 0.
REQ-038 Back-to-back: rxValid on consecutive cycles for 255 bytes -> 255 writes at addresses 0..254; dataLength=255; overflow=0.
